nibble_serial_adder: RTL and testbench

- Multi-cycle WIDTH-bit adder controller that sits directly upstream and downstream of the team's 4-bit carry-lookahead adder.
- Slices captured operands into 4-bit nibbles, LSB first, and drives one nibble per cycle into the external 4-bit adder.
- Collects each nibble sum and carries the nibble carry-out into the next cycle.
- Presents the full WIDTH-bit result through a valid/ready handshake.

---
 rtl/nibble_serial_adder.sv | 128 ++++++++++++
 tb/tb_nibble_serial_adder.sv | 177 +++++++++++++++++
 2 files changed

// File: rtl/nibble_serial_adder.sv
// nibble_serial_adder: multi-cycle WIDTH-bit adder controller that feeds an
// external 4-bit adder one nibble per cycle (LSB first) and chains the carry.
// Result is offered on a valid/ready handshake.
// Optional build macro: NIBBLE_ADDER_OVF_EN enables the signed overflow flag
// (otherwise Ovf is tied low).
module nibble_serial_adder #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             Cin,
    output logic [3:0]       add_a,
    output logic [3:0]       add_b,
    output logic             add_cin,
    input  logic [3:0]       add_sum,
    input  logic             add_cout,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] Sum,
    output logic             Cout,
    output logic             Ovf
);

    localparam int NIB = WIDTH / 4;
    localparam int IW  = (NIB > 1) ? $clog2(NIB) : 1;
    localparam logic [IW-1:0] LAST = IW'(NIB - 1);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t           state;
    logic [IW-1:0]    idx;
    logic             carry;
    logic [WIDTH-1:0] opa;
    logic [WIDTH-1:0] opb;

    assign in_ready = (state == IDLE);

    // Nibble mux toward the external adder; constant-select loop keeps every
    // slice in range for any legal WIDTH, including WIDTH=4.
    always_comb begin
        add_a   = '0;
        add_b   = '0;
        add_cin = 1'b0;
        if (state == RUN) begin
            add_cin = carry;
            for (int unsigned i = 0; i < NIB; i++) begin
                if (idx == IW'(i)) begin
                    add_a = opa[4*i +: 4];
                    add_b = opb[4*i +: 4];
                end
            end
        end
    end

`ifdef NIBBLE_ADDER_OVF_EN
    logic c_msb;
    assign c_msb = add_a[3] ^ add_b[3] ^ add_sum[3];
`else
    assign Ovf = 1'b0;
`endif

    // Controller FSM with registered result, carry chain and handshake.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            idx       <= '0;
            carry     <= 1'b0;
            opa       <= '0;
            opb       <= '0;
            Sum       <= '0;
            Cout      <= 1'b0;
            out_valid <= 1'b0;
`ifdef NIBBLE_ADDER_OVF_EN
            Ovf       <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        opa   <= A;
                        opb   <= B;
                        carry <= Cin;
                        idx   <= '0;
                        Sum   <= '0;
`ifdef NIBBLE_ADDER_OVF_EN
                        Ovf   <= 1'b0;
`endif
                        state <= RUN;
                    end
                end
                RUN: begin
                    for (int unsigned i = 0; i < NIB; i++) begin
                        if (idx == IW'(i)) begin
                            Sum[4*i +: 4] <= add_sum;
                        end
                    end
                    carry <= add_cout;
                    if (idx == LAST) begin
                        Cout      <= add_cout;
`ifdef NIBBLE_ADDER_OVF_EN
                        Ovf       <= c_msb ^ add_cout;
`endif
                        out_valid <= 1'b1;
                        state     <= DONE;
                    end else begin
                        idx <= idx + 1'b1;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_nibble_serial_adder.sv
// Testbench for nibble_serial_adder: WIDTH=16 and WIDTH=4 instances, each
// wired to a behavioural 4-bit adder. Expected results come from plain
// WIDTH-bit arithmetic on the operands.
module tb_nibble_serial_adder;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    // WIDTH=16 instance
    logic        in_valid, in_ready, Cin, out_valid, out_ready, Cout, Ovf;
    logic [15:0] A, B, Sum;
    logic [3:0]  add_a, add_b, add_sum;
    logic        add_cin, add_cout;

    // WIDTH=4 instance
    logic        in_valid4, in_ready4, Cin4, out_valid4, out_ready4, Cout4, Ovf4;
    logic [3:0]  A4, B4, Sum4;
    logic [3:0]  add_a4, add_b4, add_sum4;
    logic        add_cin4, add_cout4;

    int checks = 0;
    int failures = 0;

    nibble_serial_adder #(.WIDTH(16)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .A(A), .B(B), .Cin(Cin), .add_a(add_a), .add_b(add_b), .add_cin(add_cin),
        .add_sum(add_sum), .add_cout(add_cout), .out_valid(out_valid),
        .out_ready(out_ready), .Sum(Sum), .Cout(Cout), .Ovf(Ovf)
    );

    nibble_serial_adder #(.WIDTH(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid4), .in_ready(in_ready4),
        .A(A4), .B(B4), .Cin(Cin4), .add_a(add_a4), .add_b(add_b4), .add_cin(add_cin4),
        .add_sum(add_sum4), .add_cout(add_cout4), .out_valid(out_valid4),
        .out_ready(out_ready4), .Sum(Sum4), .Cout(Cout4), .Ovf(Ovf4)
    );

    // Behavioural 4-bit adders
    assign {add_cout, add_sum}   = {1'b0, add_a}  + {1'b0, add_b}  + {4'b0, add_cin};
    assign {add_cout4, add_sum4} = {1'b0, add_a4} + {1'b0, add_b4} + {4'b0, add_cin4};

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic exp_ovf(input int w, input logic [15:0] a,
                                     input logic [15:0] b, input logic [15:0] s);
`ifdef NIBBLE_ADDER_OVF_EN
        return (a[w-1] == b[w-1]) && (s[w-1] != a[w-1]);
`else
        return 1'b0;
`endif
    endfunction

    // One full transaction on the 16-bit instance with a consumer stall.
    task automatic run_op(input logic [15:0] a, input logic [15:0] b,
                          input logic cin, input int stall, input string tag);
        logic [16:0] full;
        logic [15:0] es;
        logic        eo;
        int          cyc;
        full = {1'b0, a} + {1'b0, b} + {16'b0, cin};
        es   = full[15:0];
        eo   = exp_ovf(16, a, b, es);

        @(negedge clk);
        chk({tag, ".in_ready"}, {31'b0, in_ready}, 32'd1);
        A = a; B = b; Cin = cin; in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        // First RUN cycle: Sum cleared, nibble 0 and carry-in presented
        chk({tag, ".sum_cleared"}, {16'b0, Sum}, 32'd0);
        chk({tag, ".add_a0"}, {28'b0, add_a}, {28'b0, a[3:0]});
        chk({tag, ".add_b0"}, {28'b0, add_b}, {28'b0, b[3:0]});
        chk({tag, ".add_cin0"}, {31'b0, add_cin}, {31'b0, cin});
        cyc = 0;
        while (!out_valid && cyc < 20) begin
            // Spurious offers during RUN must be ignored
            in_valid = 1'($urandom);
            A = 16'($urandom); B = 16'($urandom); Cin = 1'($urandom);
            @(negedge clk);
            cyc++;
        end
        in_valid = 1'b0;
        chk({tag, ".latency"}, cyc, 32'd4);
        chk({tag, ".sum"}, {16'b0, Sum}, {16'b0, es});
        chk({tag, ".cout"}, {31'b0, Cout}, {31'b0, full[16]});
        chk({tag, ".ovf"}, {31'b0, Ovf}, {31'b0, eo});
        chk({tag, ".add_idle"}, {23'b0, add_a, add_b, add_cin}, 32'd0);
        for (int i = 0; i < stall; i++) begin
            in_valid = 1'($urandom);
            A = 16'($urandom);
            @(negedge clk);
            chk({tag, ".hold_valid"}, {31'b0, out_valid}, 32'd1);
            chk({tag, ".hold_sum"}, {15'b0, Cout, Sum}, {15'b0, full[16], es});
            chk({tag, ".hold_busy"}, {31'b0, in_ready}, 32'd0);
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        chk({tag, ".valid_drop"}, {31'b0, out_valid}, 32'd0);
        chk({tag, ".ready_back"}, {31'b0, in_ready}, 32'd1);
    endtask

    initial begin
        in_valid = 0; A = '0; B = '0; Cin = 0; out_ready = 0;
        in_valid4 = 0; A4 = '0; B4 = '0; Cin4 = 0; out_ready4 = 0;
        repeat (2) @(negedge clk);
        chk("rst.out_valid_async", {31'b0, out_valid}, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("rst.in_ready", {31'b0, in_ready}, 32'd1);
        chk("rst.out_valid", {31'b0, out_valid}, 32'd0);
        chk("rst.sum", {15'b0, Cout, Sum}, 32'd0);
        chk("rst.ovf", {31'b0, Ovf}, 32'd0);
        chk("rst.add", {23'b0, add_a, add_b, add_cin}, 32'd0);

        // out_ready with nothing pending has no effect
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        chk("idle.out_ready_noeffect", {30'b0, out_valid, in_ready}, 32'd1);

        run_op(16'hFFFF, 16'h0001, 1'b0, 0, "ripple");
        run_op(16'h1234, 16'h4321, 1'b1, 3, "stall");
        run_op(16'h7FFF, 16'h0001, 1'b0, 1, "ovf");

        // Reset during RUN at idx=2
        @(negedge clk);
        A = 16'hAAAA; B = 16'h5555; Cin = 1'b1; in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("midrst.idx2_nibble", {28'b0, add_a}, 32'hA);
        #1 rst_n = 1'b0;
        #1;
        chk("midrst.out_valid", {31'b0, out_valid}, 32'd0);
        chk("midrst.in_ready", {31'b0, in_ready}, 32'd1);
        chk("midrst.sum", {15'b0, Cout, Sum}, 32'd0);
        chk("midrst.add", {23'b0, add_a, add_b, add_cin}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        run_op(16'h0010, 16'h0020, 1'b0, 0, "after_rst");

        for (int n = 0; n < 20; n++) begin
            run_op(16'($urandom), 16'($urandom), 1'($urandom),
                   int'($urandom_range(0, 3)), "rand");
        end

        // WIDTH=4 instance: one RUN cycle
        @(negedge clk);
        A4 = 4'hF; B4 = 4'h1; Cin4 = 1'b1; in_valid4 = 1'b1;
        @(negedge clk);
        in_valid4 = 1'b0;
        chk("w4.run_nibble", {23'b0, add_a4, add_b4, add_cin4}, {23'b0, 4'hF, 4'h1, 1'b1});
        chk("w4.run_not_valid", {31'b0, out_valid4}, 32'd0);
        @(negedge clk);
        chk("w4.valid", {31'b0, out_valid4}, 32'd1);
        chk("w4.sum", {27'b0, Cout4, Sum4}, {27'b0, 1'b1, 4'h1});
        chk("w4.ovf", {31'b0, Ovf4}, {31'b0, exp_ovf(4, 16'hF, 16'h1, 16'h1)});
        out_ready4 = 1'b1;
        @(negedge clk);
        out_ready4 = 1'b0;
        chk("w4.release", {30'b0, out_valid4, in_ready4}, 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
